// File: rtl/reg_scoreboard_if.sv
// ---------------------------------------------------------------------------
// reg_scoreboard_if
//   Issue / retire / flush handshake between the pipeline and the GPR write
//   scoreboard.
//   master : pipeline side (decode + writeback), drives requests.
//   slave  : scoreboard side, returns issue_ready, busy_vec, underflow_err.
// ---------------------------------------------------------------------------
interface reg_scoreboard_if;
    logic        issue_valid;
    logic        issue_wen;
    logic [4:0]  issue_dest;
    logic [4:0]  issue_rs;
    logic [4:0]  issue_rt;
    logic        issue_ready;
    logic        retire_valid;
    logic [4:0]  retire_dest;
    logic        flush;
    logic [31:0] busy_vec;
    logic        underflow_err;

    modport master (
        output issue_valid, issue_wen, issue_dest, issue_rs, issue_rt,
        output retire_valid, retire_dest, flush,
        input  issue_ready, busy_vec, underflow_err
    );

    modport slave (
        input  issue_valid, issue_wen, issue_dest, issue_rs, issue_rt,
        input  retire_valid, retire_dest, flush,
        output issue_ready, busy_vec, underflow_err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//   Tracks in-flight GPR writes with one saturating-free counter per register
//   and stalls issue on source hazards or a full destination counter.
//   Ports:
//     clk     - sole clock, rising edge
//     resetn  - asynchronous active-low reset
//     sb      - reg_scoreboard_if.slave (issue, retire, flush, status)
//   Parameter:
//     CNT_W   - width of each per-register in-flight counter
// ---------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic              clk,
    input  logic              resetn,
    reg_scoreboard_if.slave   sb
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt [32];
    logic [31:0]      busy;
    logic [31:0]      issue_sel;
    logic [31:0]      retire_sel;
    logic [31:0]      inc;
    logic [31:0]      dec;
    logic             src_hazard;
    logic             full_hazard;
    logic             ready;
    logic             fire;
    logic             underflow_err;
    logic             underflow_hit;

    // Status and decodes come from registered counters only, so a retire in
    // the current cycle cannot release a hazard until the following cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        busy        = '0;
        issue_sel   = 32'd1 << sb.issue_dest;
        retire_sel  = 32'd1 << sb.retire_dest;
        for (int i = 1; i < 32; i++) begin
            busy[i] = (cnt[i] != '0);
        end

        src_hazard  = busy[sb.issue_rs] | busy[sb.issue_rt];
        full_hazard = sb.issue_wen & (sb.issue_dest != 5'd0) &
                      (cnt[sb.issue_dest] == CNT_MAX);
        ready       = !src_hazard & !full_hazard & !sb.flush;
        fire        = sb.issue_valid & ready;

        // Register 0 is never tracked; bit 0 of inc/dec is forced low.
        inc         = (fire & sb.issue_wen) ? issue_sel : '0;
        inc[0]      = 1'b0;
        dec         = sb.retire_valid ? (retire_sel & busy) : '0;
        dec[0]      = 1'b0;

        underflow_hit = sb.retire_valid & (sb.retire_dest != 5'd0) &
                        (cnt[sb.retire_dest] == '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: the counter array is reset because hazard state must be empty
        // the instant reset is applied; it is flops, not a RAM.
        if (!resetn) begin
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= '0;
            end
        end else if (sb.flush) begin
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            // cnt[0] is never written after reset and therefore stays zero.
            for (int i = 1; i < 32; i++) begin
                if (inc[i] && !dec[i]) begin
                    // NOTE: sequential state uses non-blocking assignment only.
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else if (dec[i] && !inc[i]) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    // Sticky error; flush deliberately leaves it alone.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            underflow_err <= 1'b0;
        end else if (underflow_hit) begin
            underflow_err <= 1'b1;
        end
    end

    assign sb.issue_ready   = ready;
    assign sb.busy_vec      = busy;
    assign sb.underflow_err = underflow_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_scoreboard
//   Directed bench for reg_scoreboard (CNT_W = 2). Inputs change 1 ns after
//   the rising edge; outputs are sampled 2 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_reg_scoreboard;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_fails;

    reg_scoreboard_if sb_if ();

    reg_scoreboard #(.CNT_W(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .sb     (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [4:0] d,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic rv, input logic [4:0] rd, input logic fl);
        sb_if.issue_valid  = v;
        sb_if.issue_wen    = w;
        sb_if.issue_dest   = d;
        sb_if.issue_rs     = rs;
        sb_if.issue_rt     = rt;
        sb_if.retire_valid = rv;
        sb_if.retire_dest  = rd;
        sb_if.flush        = fl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_w(input logic [4:0] d);
        drive(1'b1, 1'b1, d, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
    endtask

    task automatic retire(input logic [4:0] d);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, d, 1'b0);
        step();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;
        resetn   = 1'b0;
        idle();
        #10;

        // Reset state
        check("rst_busy", sb_if.busy_vec, 32'h0);
        check("rst_ready", 32'(sb_if.issue_ready), 32'h1);
        check("rst_err", 32'(sb_if.underflow_err), 32'h0);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        check("rst_flush_ready", 32'(sb_if.issue_ready), 32'h0);
        idle();

        @(negedge clk);
        resetn = 1'b1;
        step();

        // First issue after reset, dest 5
        drive(1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        check("iss5_ready", 32'(sb_if.issue_ready), 32'h1);
        step();
        idle();
        check("iss5_busy", sb_if.busy_vec, 32'h0000_0020);

        // Source hazard on rs=5, retire same cycle: no bypass
        drive(1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        check("haz_rs5", 32'(sb_if.issue_ready), 32'h0);
        drive(1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0);
        check("haz_nobypass", 32'(sb_if.issue_ready), 32'h0);
        step();
        drive(1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        check("haz_released", 32'(sb_if.issue_ready), 32'h1);
        check("haz_busy0", sb_if.busy_vec, 32'h0);
        idle();

        // Counter fill on dest 7
        issue_w(5'd7);
        issue_w(5'd7);
        issue_w(5'd7);
        drive(1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        check("full7_ready", 32'(sb_if.issue_ready), 32'h0);
        check("full7_busy", sb_if.busy_vec, 32'h0000_0080);
        step();
        retire(5'd7);                         // cnt 3 -> 2
        drive(1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b1, 5'd7, 1'b0);
        check("both7_ready", 32'(sb_if.issue_ready), 32'h1);
        step();                               // inc & dec: stays 2
        issue_w(5'd7);                        // 2 -> 3
        drive(1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        check("both7_cnt_full", 32'(sb_if.issue_ready), 32'h0);
        idle();
        retire(5'd7);
        retire(5'd7);
        check("drain7_busy_mid", sb_if.busy_vec, 32'h0000_0080);
        retire(5'd7);
        check("drain7_busy", sb_if.busy_vec, 32'h0);
        check("drain7_err", 32'(sb_if.underflow_err), 32'h0);

        // Register 0 is never tracked
        drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        check("r0_issue_ready", 32'(sb_if.issue_ready), 32'h1);
        step();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        check("r0_busy", sb_if.busy_vec, 32'h0);
        check("r0_src_ready", 32'(sb_if.issue_ready), 32'h1);
        retire(5'd0);
        idle();
        check("r0_retire_err", 32'(sb_if.underflow_err), 32'h0);

        // Underflow on empty register 9
        retire(5'd9);
        idle();
        check("uf9_err", 32'(sb_if.underflow_err), 32'h1);
        check("uf9_busy", sb_if.busy_vec, 32'h0);
        issue_w(5'd9);
        check("uf9_busy_after_issue", sb_if.busy_vec, 32'h0000_0200);
        retire(5'd9);
        idle();
        check("uf9_err_sticky", 32'(sb_if.underflow_err), 32'h1);
        check("uf9_busy_clear", sb_if.busy_vec, 32'h0);

        // Flush overrides a concurrent issue
        issue_w(5'd8);
        issue_w(5'd9);
        issue_w(5'd10);
        issue_w(5'd11);
        idle();
        check("fl_busy_pre", sb_if.busy_vec, 32'h0000_0F00);
        drive(1'b1, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        check("fl_ready", 32'(sb_if.issue_ready), 32'h0);
        step();
        idle();
        check("fl_busy_post", sb_if.busy_vec, 32'h0);
        check("fl_err_kept", 32'(sb_if.underflow_err), 32'h1);

        // rt hazard, then asynchronous reset mid-cycle
        issue_w(5'd12);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd12, 1'b0, 5'd0, 1'b0);
        check("haz_rt12", 32'(sb_if.issue_ready), 32'h0);
        idle();
        check("pre_rst_busy", sb_if.busy_vec, 32'h0000_1000);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_busy", sb_if.busy_vec, 32'h0);
        check("async_rst_err", 32'(sb_if.underflow_err), 32'h0);
        check("async_rst_ready", 32'(sb_if.issue_ready), 32'h1);
        @(negedge clk);
        resetn = 1'b1;
        step();

        // First edge after release starts from empty
        issue_w(5'd6);
        idle();
        check("post_rst_busy", sb_if.busy_vec, 32'h0000_0040);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
